// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin codes, coin value helper and change dispenser state type
package vm_pkg;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_5    = 3'b001;
    localparam logic [2:0] COIN_10   = 3'b010;
    localparam logic [2:0] COIN_20   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        PAY  = 2'd2,
        DONE = 2'd3
    } chg_state_t;

    // Monetary value of a one-hot coin code; anything else is worth nothing.
    function automatic logic [7:0] coin_value(input logic [2:0] coin);
        case (coin)
            COIN_5:  coin_value = 8'd5;
            COIN_10: coin_value = 8'd10;
            COIN_20: coin_value = 8'd20;
            default: coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, coin handshake and status bundle of the change dispenser
interface change_dispenser_if;

    logic       req;
    logic [7:0] change_in;
    logic       coin_ack;
    logic       refill;
    logic       busy;
    logic [2:0] coin_out;
    logic       coin_valid;
    logic       done_pay;
    logic       short_pay;
    logic [7:0] remain;
    logic [2:0] stock_empty;

    modport master (
        output req, change_in, coin_ack, refill,
        input  busy, coin_out, coin_valid, done_pay, short_pay, remain, stock_empty
    );

    modport slave (
        input  req, change_in, coin_ack, refill,
        output busy, coin_out, coin_valid, done_pay, short_pay, remain, stock_empty
    );

endinterface

// File: rtl/chg_coin_picker.sv
// rtl/chg_coin_picker.sv - greedy choice of the largest payable coin that is in stock
module chg_coin_picker
    import vm_pkg::*;
(
    input  logic [7:0] remain,
    input  logic [2:0] avail,
    output logic [2:0] coin
);

    // Largest denomination first; 000 when nothing fits or nothing is in stock.
    always_comb begin
        coin = COIN_NONE;
        if (remain >= 8'd20 && avail[2]) begin
            coin = COIN_20;
        end else if (remain >= 8'd10 && avail[1]) begin
            coin = COIN_10;
        end else if (remain >= 8'd5 && avail[0]) begin
            coin = COIN_5;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - converts a change amount into a stream of one-hot coins (CHG_STOCK_EN: finite stock)
module change_dispenser
    import vm_pkg::*;
#(
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    change_dispenser_if.slave    bus
);

    chg_state_t state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic       busy_q, busy_d;
    logic [2:0] coin_q, coin_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       short_q, short_d;
    logic [2:0] avail;
    logic [2:0] pick;
    logic       not_mult5;

`ifdef CHG_STOCK_EN
    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

    logic [STOCK_W-1:0] stock_q [3];
    logic [STOCK_W-1:0] stock_d [3];
    logic [2:0]         empty;

    // A denomination is eligible only while its counter is non-zero.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i] = (stock_q[i] == '0);
        end
    end

    assign avail           = ~empty;
    assign bus.stock_empty = empty;
`else
    localparam int unused_stock_cfg = STOCK_W + INIT_STOCK;

    logic unused_refill;

    assign unused_refill   = bus.refill;
    assign avail           = 3'b111;
    assign bus.stock_empty = 3'b000;
`endif

    assign not_mult5 = ((remain_q % 8'd5) != 8'd0);

    chg_coin_picker u_picker (
        .remain (remain_q),
        .avail  (avail),
        .coin   (pick)
    );

    // State and registered outputs; reset drops any pending coin and reloads stock.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            remain_q <= 8'd0;
            busy_q   <= 1'b0;
            coin_q   <= COIN_NONE;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
`ifdef CHG_STOCK_EN
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= INIT_VAL;
            end
`endif
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            busy_q   <= busy_d;
            coin_q   <= coin_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            short_q  <= short_d;
`ifdef CHG_STOCK_EN
            for (int i = 0; i < 3; i++) begin
                stock_q[i] <= stock_d[i];
            end
`endif
        end
    end

    // Next-state and next-output decisions for the payout sequence.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        busy_d   = busy_q;
        coin_d   = coin_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        short_d  = short_q;
`ifdef CHG_STOCK_EN
        for (int i = 0; i < 3; i++) begin
            stock_d[i] = stock_q[i];
        end
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
`ifdef CHG_STOCK_EN
                if (bus.refill) begin
                    for (int i = 0; i < 3; i++) begin
                        stock_d[i] = INIT_VAL;
                    end
                end
`endif
                if (bus.req) begin
                    remain_d = bus.change_in;
                    busy_d   = 1'b1;
                    short_d  = 1'b0;
                    state_d  = PICK;
                end
            end
            PICK: begin
                if (remain_q == 8'd0) begin
                    done_d  = 1'b1;
                    short_d = 1'b0;
                    state_d = DONE;
                end else if (not_mult5 || pick == COIN_NONE) begin
                    // Unpayable amount or out of suitable coins: leftover stays in remain.
                    done_d  = 1'b1;
                    short_d = 1'b1;
                    state_d = DONE;
                end else begin
                    coin_d  = pick;
                    valid_d = 1'b1;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (bus.coin_ack) begin
                    remain_d = remain_q - coin_value(coin_q);
`ifdef CHG_STOCK_EN
                    for (int i = 0; i < 3; i++) begin
                        if (coin_q[i] && stock_q[i] != '0) begin
                            stock_d[i] = stock_q[i] - 1'b1;
                        end
                    end
`endif
                    coin_d  = COIN_NONE;
                    valid_d = 1'b0;
                    state_d = PICK;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy       = busy_q;
    assign bus.coin_out   = coin_q;
    assign bus.coin_valid = valid_q;
    assign bus.done_pay   = done_q;
    assign bus.short_pay  = short_q;
    assign bus.remain     = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;

    logic clk = 1'b0;
    logic reset_n;

    change_dispenser_if bus ();

    change_dispenser #(
        .STOCK_W    (4),
        .INIT_STOCK (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  amt;
        int          ncoin;
        logic [47:0] coins;
        int          hold;
        bit          poke;
        bit          exp_short;
        logic [7:0]  exp_rem;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] amt, input int ncoin, input logic [47:0] coins,
                                input int hold, input bit poke, input bit sh, input logic [7:0] rem);
        vec_t v;
        v.amt = amt; v.ncoin = ncoin; v.coins = coins; v.hold = hold;
        v.poke = poke; v.exp_short = sh; v.exp_rem = rem;
        return v;
    endfunction

    // Drives one request (with refill in the same cycle) and checks every coin and the final status.
    task automatic run_vec(input vec_t v, input string tag);
        logic [2:0] exp_coin;
        bus.req       = 1'b1;
        bus.refill    = 1'b1;
        bus.change_in = v.amt;
        @(negedge clk);
        bus.req    = 1'b0;
        bus.refill = 1'b0;
        check({tag, " busy_after_req"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < v.ncoin; k++) begin
            exp_coin = v.coins[3*k +: 3];
            @(negedge clk);
            check($sformatf("%s coin%0d_valid", tag, k), 32'(bus.coin_valid), 32'd1);
            check($sformatf("%s coin%0d_code", tag, k), 32'(bus.coin_out), 32'(exp_coin));
            for (int d = 0; d < v.hold; d++) begin
                bus.req       = v.poke && (d == 1);
                bus.change_in = 8'd5;
                @(negedge clk);
                check($sformatf("%s coin%0d_hold%0d", tag, k, d),
                      {28'd0, bus.coin_valid, bus.coin_out}, {28'd0, 1'b1, exp_coin});
            end
            bus.req      = 1'b0;
            bus.coin_ack = 1'b1;
            @(negedge clk);
            bus.coin_ack = 1'b0;
            check($sformatf("%s coin%0d_dropped", tag, k),
                  {28'd0, bus.coin_valid, bus.coin_out}, 32'd0);
        end
        @(negedge clk);
        check({tag, " done_pay"}, 32'(bus.done_pay), 32'd1);
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd1);
        check({tag, " short_pay"}, 32'(bus.short_pay), 32'(v.exp_short));
        check({tag, " remain"}, 32'(bus.remain), 32'(v.exp_rem));
        @(negedge clk);
        check({tag, " done_one_cycle"}, {30'd0, bus.done_pay, bus.busy}, 32'd0);
        check({tag, " remain_held"}, 32'(bus.remain), 32'(v.exp_rem));
    endtask

    initial begin
        logic [47:0] big;
        reset_n       = 1'b0;
        bus.req       = 1'b0;
        bus.change_in = 8'd0;
        bus.coin_ack  = 1'b0;
        bus.refill    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {19'd0, bus.busy, bus.coin_valid, bus.done_pay, bus.short_pay, bus.coin_out, bus.remain},
              32'd0);
        check("reset_stock_empty", 32'(bus.stock_empty), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(8'd35, 3, 48'(9'b001_010_100), 0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'd0,  0, 48'd0,               0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'd7,  0, 48'd0,               0, 1'b0, 1'b1, 8'd7));
        vecs.push_back(mk(8'd13, 0, 48'd0,               0, 1'b0, 1'b1, 8'd13));
        vecs.push_back(mk(8'd15, 2, 48'(6'b001_010),     0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'd5,  1, 48'(3'b001),         0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'd30, 2, 48'(6'b010_100),     5, 1'b1, 1'b0, 8'd0));
`ifdef CHG_STOCK_EN
        vecs.push_back(mk(8'd40,  3, 48'(9'b001_010_100), 0, 1'b0, 1'b1, 8'd5));
        vecs.push_back(mk(8'd255, 3, 48'(9'b001_010_100), 0, 1'b0, 1'b1, 8'd220));
`else
        vecs.push_back(mk(8'd40, 2, 48'(6'b100_100), 0, 1'b0, 1'b0, 8'd0));
        big = '0;
        for (int i = 0; i < 12; i++) begin
            big[3*i +: 3] = 3'b100;
        end
        big[36 +: 3] = 3'b010;
        big[39 +: 3] = 3'b001;
        vecs.push_back(mk(8'd255, 14, big, 0, 1'b0, 1'b0, 8'd0));
`endif

        foreach (vecs[i]) begin
            run_vec(vecs[i], $sformatf("v%0d_amt%0d", i, vecs[i].amt));
        end

        // Reset while a coin is pending.
        bus.req       = 1'b1;
        bus.refill    = 1'b0;
        bus.change_in = 8'd35;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("midpay_coin_valid", 32'(bus.coin_valid), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midpay_reset_outputs",
              {19'd0, bus.busy, bus.coin_valid, bus.done_pay, bus.short_pay, bus.coin_out, bus.remain},
              32'd0);
        check("midpay_reset_stock", 32'(bus.stock_empty), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

`ifdef CHG_STOCK_EN
        // Drain every denomination, then refill from IDLE.
        run_vec(mk(8'd40, 3, 48'(9'b001_010_100), 0, 1'b0, 1'b1, 8'd5), "drain40");
        check("drain_stock_empty", 32'(bus.stock_empty), 32'd7);
        bus.refill = 1'b1;
        @(negedge clk);
        bus.refill = 1'b0;
        @(negedge clk);
        check("refill_stock_empty", 32'(bus.stock_empty), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
